rv32_alu_decode: RTL and testbench

- Decode stage that feeds the RV32 ALU: accepts fetched instructions over a valid/ready handshake and produces alu_opsel, the register addresses, a pass-through code_bus and the pc.
- Holds one registered output slot, so decode adds exactly one pipeline stage between fetch and execute.
- Detects instructions the ALU cannot execute, raises a trap and stalls until the trap is acknowledged.

---
 rtl/rv32_alu_decode_pkg.sv | 43 ++++
 rtl/rv32_instr_decode.sv | 72 +++++++
 rtl/rv32_alu_decode.sv | 99 +++++++++
 tb/tb_rv32_alu_decode.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_alu_decode_pkg.sv
// Shared constants and types for the RV32 ALU decode stage.
// Opcodes, ALU operation codes, decode bundle and FSM state encoding.
package rv32_alu_decode_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_ADDI  = 4'd7,
    ALU_RSVD  = 4'd8,
    ALU_XORI  = 4'd9,
    ALU_ORI   = 4'd10,
    ALU_ANDI  = 4'd11,
    ALU_SLTI  = 4'd12,
    ALU_SLTIU = 4'd13,
    ALU_LUI   = 4'd14,
    ALU_AUIPC = 4'd15
  } alu_op_e;

  typedef struct packed {
    alu_op_e    opsel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_t;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

endpackage

// File: rtl/rv32_instr_decode.sv
// Combinational RV32 ALU instruction decoder.
// Maps a raw word to opsel, register indices and an illegal flag.
module rv32_instr_decode
  import rv32_alu_decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  // Classify by opcode/funct, then trim unused register fields.
  always_comb begin
    dec.opsel   = ALU_ADD;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = 1'b1;
    unique case (1'b1)
      (op == OP_R) && (f7 == F7_BASE): begin
        dec.illegal = 1'b0;
        case (f3)
          3'b000: dec.opsel = ALU_ADD;
          3'b100: dec.opsel = ALU_XOR;
          3'b110: dec.opsel = ALU_OR;
          3'b111: dec.opsel = ALU_AND;
          3'b010: dec.opsel = ALU_SLT;
          3'b011: dec.opsel = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      (op == OP_R) && (f7 == F7_ALT): begin
        dec.illegal = (f3 != 3'b000);
        dec.opsel   = dec.illegal ? ALU_ADD
                                  : ALU_SUB;
      end
      (op == OP_I): begin
        dec.illegal = 1'b0;
        case (f3)
          3'b000: dec.opsel = ALU_ADDI;
          3'b100: dec.opsel = ALU_XORI;
          3'b110: dec.opsel = ALU_ORI;
          3'b111: dec.opsel = ALU_ANDI;
          3'b010: dec.opsel = ALU_SLTI;
          3'b011: dec.opsel = ALU_SLTIU;
          default: dec.illegal = 1'b1;
        endcase
        if (!dec.illegal) dec.rs2 = '0;
      end
      (op == OP_LUI): begin
        dec.illegal = 1'b0;
        dec.opsel   = ALU_LUI;
        dec.rs1     = '0;
        dec.rs2     = '0;
      end
      (op == OP_AUIPC): begin
        dec.illegal = 1'b0;
        dec.opsel   = ALU_AUIPC;
        dec.rs1     = '0;
        dec.rs2     = '0;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_alu_decode.sv
// RV32 ALU decode stage: one output slot, trap FSM.
// Illegal consumes trap until acknowledged; counter saturates.
module rv32_alu_decode
  import rv32_alu_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           alu_opsel,
  output logic                 alu_enable,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output logic [4:0]           rd_addr,
  output logic [31:0]          code_bus,
  output logic [XLEN-1:0]      pc,
  output logic                 out_illegal,
  output logic                 trap,
  input  logic                 trap_ack,
  output logic [ILL_CNT_W-1:0] ill_count
);

  dec_t            dec;
  dec_t            dec_q;
  logic            vld_q;
  logic [31:0]     code_q;
  logic [XLEN-1:0] pc_q;
  logic [0:0]      state_q;
  logic            accept;
  logic            consume;
  logic            ill_take;

  rv32_instr_decode u_dec (
    .instr (in_instr),
    .dec   (dec)
  );

  assign out_valid = vld_q && (state_q == ST_RUN);
  assign in_ready  = (state_q == ST_RUN)
                   && (!out_valid || out_ready)
                   && !flush;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready && !flush;
  assign ill_take  = consume && dec_q.illegal;

  assign alu_opsel   = dec_q.opsel;
  assign rs1_addr    = dec_q.rs1;
  assign rs2_addr    = dec_q.rs2;
  assign rd_addr     = dec_q.rd;
  assign out_illegal = dec_q.illegal;
  assign alu_enable  = out_valid && !dec_q.illegal;
  assign code_bus    = code_q;
  assign pc          = pc_q;
  assign trap        = (state_q == ST_TRAP);

  // Output slot: flush beats accept, accept beats consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      dec_q  <= '0;
      code_q <= '0;
      pc_q   <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      dec_q  <= dec;
      code_q <= in_instr;
      pc_q   <= in_pc;
    end else if (consume) begin
      vld_q <= 1'b0;
    end
  end

  // Trap FSM and saturating illegal counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ill_count <= '0;
    end else begin
      if (state_q == ST_RUN) begin
        if (ill_take) state_q <= ST_TRAP;
      end else if (trap_ack) begin
        state_q <= ST_RUN;
      end
      if (ill_take && (ill_count != '1))
        ill_count <= ill_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_alu_decode.sv
// Self-checking bench for rv32_alu_decode.
// Vector table for decode, directed runs for handshake/trap.
module tb_rv32_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opsel;
  logic        alu_enable;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] code_bus;
  logic [31:0] pc;
  logic        out_illegal;
  logic        trap;
  logic        trap_ack;
  logic [7:0]  ill_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_alu_decode #(
    .XLEN      (32),
    .ILL_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_opsel   (alu_opsel),
    .alu_enable  (alu_enable),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .code_bus    (code_bus),
    .pc          (pc),
    .out_illegal (out_illegal),
    .trap        (trap),
    .trap_ack    (trap_ack),
    .ill_count   (ill_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 20;
  vec_t tv[NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins,
                     input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = p;
  endtask

  initial begin
    tv[0]  = '{32'h002081B3, 4'd0,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[1]  = '{32'h402081B3, 4'd1,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[2]  = '{32'h0020C1B3, 4'd2,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[3]  = '{32'h0020E1B3, 4'd3,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[4]  = '{32'h0020F1B3, 4'd4,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[5]  = '{32'h0020A1B3, 4'd5,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[6]  = '{32'h0020B1B3, 4'd6,  5'd1, 5'd2, 5'd3, 1'b0};
    tv[7]  = '{32'hFFF08093, 4'd7,  5'd1, 5'd0, 5'd1, 1'b0};
    tv[8]  = '{32'h0FF0C093, 4'd9,  5'd1, 5'd0, 5'd1, 1'b0};
    tv[9]  = '{32'h0FF0E093, 4'd10, 5'd1, 5'd0, 5'd1, 1'b0};
    tv[10] = '{32'h0FF0F093, 4'd11, 5'd1, 5'd0, 5'd1, 1'b0};
    tv[11] = '{32'h0FF0A093, 4'd12, 5'd1, 5'd0, 5'd1, 1'b0};
    tv[12] = '{32'h0FF0B093, 4'd13, 5'd1, 5'd0, 5'd1, 1'b0};
    tv[13] = '{32'h123450B7, 4'd14, 5'd0, 5'd0, 5'd1, 1'b0};
    tv[14] = '{32'h12345097, 4'd15, 5'd0, 5'd0, 5'd1, 1'b0};
    tv[15] = '{32'h00109093, 4'd0,  5'd1, 5'd1, 5'd1, 1'b1};
    tv[16] = '{32'h022081B3, 4'd0,  5'd1, 5'd2, 5'd3, 1'b1};
    tv[17] = '{32'h4020C1B3, 4'd0,  5'd1, 5'd2, 5'd3, 1'b1};
    tv[18] = '{32'h0020D1B3, 4'd0,  5'd1, 5'd2, 5'd3, 1'b1};
    tv[19] = '{32'h00208063, 4'd0,  5'd1, 5'd2, 5'd0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    trap_ack  = 1'b0;
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst trap", trap, 0);
    chk("rst ill_count", ill_count, 0);
    chk("rst code_bus", code_bus, 0);
    chk("rst pc", pc, 0);
    chk("rst opsel", alu_opsel, 0);
    chk("rst alu_enable", alu_enable, 0);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 1);

    // Decode table: accept, inspect, then flush away.
    for (int i = 0; i < NV; i++) begin
      put(tv[i].instr, 32'h200 + 32'(4 * i));
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d valid", i), out_valid, 1);
      chk($sformatf("v%0d opsel", i), alu_opsel, tv[i].op);
      chk($sformatf("v%0d rs1", i), rs1_addr, tv[i].rs1);
      chk($sformatf("v%0d rs2", i), rs2_addr, tv[i].rs2);
      chk($sformatf("v%0d rd", i), rd_addr, tv[i].rd);
      chk($sformatf("v%0d ill", i), out_illegal, tv[i].ill);
      chk($sformatf("v%0d en", i), alu_enable, !tv[i].ill);
      chk($sformatf("v%0d code", i), code_bus, tv[i].instr);
      chk($sformatf("v%0d pc", i), pc, 32'h200 + 32'(4 * i));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk($sformatf("v%0d flushed", i), out_valid, 0);
    end
    chk("flush no count", ill_count, 0);
    chk("flush no trap", trap, 0);

    // ADD x3,x1,x2 at pc 0x100.
    put(32'h002081B3, 32'h100);
    step();
    in_valid = 1'b0;
    #1;
    chk("add valid", out_valid, 1);
    chk("add opsel", alu_opsel, 0);
    chk("add rs1", rs1_addr, 1);
    chk("add rs2", rs2_addr, 2);
    chk("add rd", rd_addr, 3);
    chk("add pc", pc, 32'h100);
    chk("add en", alu_enable, 1);

    // Back-to-back SUB, ANDI, LUI at full rate.
    out_ready = 1'b1;
    put(32'h402081B3, 32'h104);
    step();
    chk("b2b sub", alu_opsel, 1);
    put(32'h0FF0F093, 32'h108);
    #1;
    chk("b2b ready", in_ready, 1);
    step();
    chk("b2b andi", alu_opsel, 11);
    put(32'h123450B7, 32'h10C);
    step();
    chk("b2b lui", alu_opsel, 14);
    chk("b2b lui rs1", rs1_addr, 0);
    chk("b2b lui rs2", rs2_addr, 0);
    chk("b2b lui valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("drain valid", out_valid, 0);

    // Stall: held ADD, XOR waiting.
    out_ready = 1'b0;
    put(32'h002081B3, 32'h110);
    step();
    put(32'h0020C1B3, 32'h114);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall code", code_bus, 32'h002081B3);
      chk("stall pc", pc, 32'h110);
      chk("stall valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("release code", code_bus, 32'h0020C1B3);
    chk("release opsel", alu_opsel, 2);
    step();
    chk("release drain", out_valid, 0);

    // Illegal SLLI, trap, ack.
    out_ready = 1'b0;
    put(32'h00109093, 32'h120);
    step();
    in_valid = 1'b0;
    #1;
    chk("slli ill", out_illegal, 1);
    chk("slli en", alu_enable, 0);
    chk("slli opsel", alu_opsel, 0);
    out_ready = 1'b1;
    step();
    chk("trap up", trap, 1);
    chk("trap count", ill_count, 1);
    chk("trap valid", out_valid, 0);
    put(32'h002081B3, 32'h124);
    #1;
    chk("trap in_ready", in_ready, 0);
    step();
    chk("trap holds", trap, 1);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    chk("ack run", trap, 0);
    chk("ack in_ready", in_ready, 1);
    step();
    chk("ack accept", out_valid, 1);
    chk("ack code", code_bus, 32'h002081B3);
    chk("ack pc", pc, 32'h124);

    // Flush with consume and fetch pending.
    put(32'h402081B3, 32'h128);
    flush = 1'b1;
    #1;
    chk("flush in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush valid", out_valid, 0);
    chk("flush code", code_bus, 32'h002081B3);

    // trap_ack outside TRAP does nothing.
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    chk("stray ack", trap, 0);

    // Counter saturation: 255 more illegal consumes.
    for (int n = 0; n < 255; n++) begin
      out_ready = 1'b0;
      put(32'h00000073, 32'h300);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
    end
    chk("sat count", ill_count, 8'hFF);

    // Enter TRAP; flush must not leave it.
    out_ready = 1'b0;
    put(32'h00000073, 32'h400);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("sat trap", trap, 1);
    chk("sat hold", ill_count, 8'hFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush in trap", trap, 1);

    // Async reset while in TRAP.
    #2 rst_n = 1'b0;
    #1;
    chk("trap rst trap", trap, 0);
    chk("trap rst count", ill_count, 0);
    chk("trap rst code", code_bus, 0);
    chk("trap rst valid", out_valid, 0);
    rst_n = 1'b1;
    step();

    // Async reset while stalled with a held instruction.
    out_ready = 1'b0;
    put(32'h0020F1B3, 32'h500);
    step();
    in_valid = 1'b0;
    #1;
    chk("pre rst valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("stall rst valid", out_valid, 0);
    chk("stall rst opsel", alu_opsel, 0);
    chk("stall rst pc", pc, 0);
    chk("stall rst rd", rd_addr, 0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
